// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debouncer state encoding and default timing constants
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } deb_state_t;

   // Defaults assume a 50 MHz system clock.
   localparam int unsigned DEB_20MS_AT_50MHZ = 1_000_000;
   localparam int unsigned REP_DELAY_500MS   = 25_000_000;
   localparam int unsigned REP_PERIOD_100MS  = 5_000_000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input bit
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button debouncer with level, edge pulses and optional auto-repeat
// Auto-repeat is built only when BTN_REPEAT_EN is defined; otherwise btn_repeat is held at 0.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_AT_50MHZ,
   parameter int unsigned REPEAT_DELAY    = REP_DELAY_500MS,
   parameter int unsigned REPEAT_PERIOD   = REP_PERIOD_100MS
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic btn_repeat
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("button_debouncer: invalid timing parameters");
   end

   logic             btn_sync;
   deb_state_t       state_d, state_q;
   logic [CNT_W-1:0] stable_cnt_d, stable_cnt_q, stable_cnt_inc;
   logic             btn_level_d, btn_level_q;
   logic             btn_rise_d, btn_rise_q;
   logic             btn_fall_d, btn_fall_q;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_sync)
   );

   // The stable count covers the cycle that entered the wait state, so the
   // accept edge lands DEBOUNCE_CYCLES edges after the synchronised change.
   always_comb begin
      state_d        = state_q;
      stable_cnt_d   = stable_cnt_q;
      btn_level_d    = btn_level_q;
      btn_rise_d     = 1'b0;
      btn_fall_d     = 1'b0;
      stable_cnt_inc = (stable_cnt_q == CNT_LAST) ? stable_cnt_q : stable_cnt_q + 1'b1;
      case (state_q)
         S_LOW: begin
            if (btn_sync) begin
               state_d      = S_WAIT_HIGH;
               stable_cnt_d = '0;
            end
         end
         S_WAIT_HIGH: begin
            if (!btn_sync) begin
               state_d      = S_LOW;
               stable_cnt_d = '0;
            end else if (stable_cnt_inc == CNT_LAST) begin
               state_d      = S_HIGH;
               stable_cnt_d = '0;
               btn_level_d  = 1'b1;
               btn_rise_d   = 1'b1;
            end else begin
               stable_cnt_d = stable_cnt_inc;
            end
         end
         S_HIGH: begin
            if (!btn_sync) begin
               state_d      = S_WAIT_LOW;
               stable_cnt_d = '0;
            end
         end
         S_WAIT_LOW: begin
            if (btn_sync) begin
               state_d      = S_HIGH;
               stable_cnt_d = '0;
            end else if (stable_cnt_inc == CNT_LAST) begin
               state_d      = S_LOW;
               stable_cnt_d = '0;
               btn_level_d  = 1'b0;
               btn_fall_d   = 1'b1;
            end else begin
               stable_cnt_d = stable_cnt_inc;
            end
         end
         default: begin
            state_d      = S_LOW;
            stable_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_LOW;
         stable_cnt_q <= '0;
         btn_level_q  <= 1'b0;
         btn_rise_q   <= 1'b0;
         btn_fall_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
         btn_level_q  <= btn_level_d;
         btn_rise_q   <= btn_rise_d;
         btn_fall_q   <= btn_fall_d;
      end
   end

   assign btn_level = btn_level_q;
   assign btn_rise  = btn_rise_q;
   assign btn_fall  = btn_fall_q;

`ifdef BTN_REPEAT_EN
   localparam int unsigned      REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned      REP_W     = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);

   logic [REP_W-1:0] rep_cnt_d, rep_cnt_q;
   logic             rep_armed_d, rep_armed_q;
   logic             rep_pulse_d, rep_pulse_q;
   logic             held_next;

   // rep_armed marks that the first (longer) delay has elapsed; the counter
   // restarts after every pulse and never fires on the release edge itself.
   always_comb begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
      rep_pulse_d = 1'b0;
      held_next   = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
      if (held_next && !btn_rise_d) begin
         rep_cnt_d   = rep_cnt_q + 1'b1;
         rep_armed_d = rep_armed_q;
         if (rep_cnt_d == (rep_armed_q ? REP_NEXT : REP_FIRST)) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
            rep_pulse_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
         rep_pulse_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
         rep_pulse_q <= rep_pulse_d;
      end
   end

   assign btn_repeat = rep_pulse_q;
`else
   assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer (table, corner sequences, random vs model)
module tb_button_debouncer;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
`ifdef BTN_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic btn_level, btn_rise, btn_fall, btn_repeat;

   int total = 0;
   int bad   = 0;

   // Reference model: counts consecutive synchronised samples that disagree
   // with the accepted level; DEB of them in a row flip the level.
   bit m_old, m_mid, m_level;
   int m_run, m_k;
   bit e_rise, e_fall, e_rep;

   typedef struct {
      bit btn;
      bit lvl;
      bit rise;
      bit fall;
   } vec_t;
   vec_t tbl[16];

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_rise   (btn_rise),
      .btn_fall   (btn_fall),
      .btn_repeat (btn_repeat)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_old   = 1'b0;
      m_mid   = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
      m_k     = 0;
      e_rise  = 1'b0;
      e_fall  = 1'b0;
      e_rep   = 1'b0;
   endtask

   task automatic model_edge(input bit b);
      bit seen;
      seen   = m_old;
      m_old  = m_mid;
      m_mid  = b;
      e_rise = 1'b0;
      e_fall = 1'b0;
      e_rep  = 1'b0;
      if (seen != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
         m_level = ~m_level;
         m_run   = 0;
         if (m_level) begin
            e_rise = 1'b1;
            m_k    = 0;
         end else begin
            e_fall = 1'b1;
         end
      end else if (m_level) begin
         m_k++;
         if (REP_EN && (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0))) e_rep = 1'b1;
      end
   endtask

   // Called at a negedge: drive, clock, then compare at the following negedge.
   task automatic cycle(input bit b);
      btn_in = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
      check_bit("model_level", btn_level, m_level);
      check_bit("model_rise", btn_rise, e_rise);
      check_bit("model_fall", btn_fall, e_fall);
      check_bit("model_repeat", btn_repeat, e_rep);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      check_bit("async_rst_level", btn_level, 1'b0);
      check_bit("async_rst_rise", btn_rise, 1'b0);
      check_bit("async_rst_fall", btn_fall, 1'b0);
      check_bit("async_rst_repeat", btn_repeat, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int rise_edge, fall_edge, rises, reps, first_rep, reps_after_fall;

      for (int i = 0; i < 8; i++) begin
         tbl[i].btn  = 1'b1;
         tbl[i].lvl  = (i >= 5);
         tbl[i].rise = (i == 5);
         tbl[i].fall = 1'b0;
      end
      for (int i = 8; i < 16; i++) begin
         tbl[i].btn  = 1'b0;
         tbl[i].lvl  = (i < 13);
         tbl[i].rise = 1'b0;
         tbl[i].fall = (i == 13);
      end

      reset  = 1'b1;
      btn_in = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_bit("reset_level", btn_level, 1'b0);
      check_bit("reset_rise", btn_rise, 1'b0);
      check_bit("reset_fall", btn_fall, 1'b0);
      check_bit("reset_repeat", btn_repeat, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0);

      // Clean press then clean release.
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].btn);
         check_bit("tbl_level", btn_level, tbl[i].lvl);
         check_bit("tbl_rise", btn_rise, tbl[i].rise);
         check_bit("tbl_fall", btn_fall, tbl[i].fall);
      end

      // Bounce: high 3, low 1, then steady high.
      rises = 0;
      rise_edge = 0;
      for (int i = 0; i < 14; i++) begin
         cycle((i == 3) ? 1'b0 : 1'b1);
         if (btn_rise === 1'b1) begin
            rises++;
            rise_edge = i + 1;
         end
      end
      check_int("bounce_rise_count", rises, 1);
      check_int("bounce_rise_edge", rise_edge, 10);

      // Asynchronous reset while held high; held button is a fresh press.
      do_reset();
      rise_edge = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1);
         if (btn_rise === 1'b1 && rise_edge == 0) rise_edge = i + 1;
      end
      check_int("post_reset_rise_edge", rise_edge, 6);

      for (int i = 0; i < 10; i++) cycle(1'b0);
      check_bit("released_level", btn_level, 1'b0);

      // Reset during S_WAIT_HIGH aborts the press.
      for (int i = 0; i < 4; i++) cycle(1'b1);
      btn_in = 1'b0;
      do_reset();
      rises = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0);
         if (btn_rise === 1'b1) rises++;
      end
      check_int("wait_reset_no_rise", rises, 0);
      check_bit("wait_reset_level", btn_level, 1'b0);

      // Long hold for auto-repeat.
      rise_edge = 0;
      fall_edge = 0;
      reps = 0;
      first_rep = 0;
      reps_after_fall = 0;
      for (int i = 0; i < 40; i++) begin
         cycle((i < 30) ? 1'b1 : 1'b0);
         if (btn_rise === 1'b1) rise_edge = i + 1;
         if (btn_fall === 1'b1) fall_edge = i + 1;
         if (btn_repeat === 1'b1) begin
            reps++;
            if (first_rep == 0) first_rep = i + 1;
            if (fall_edge != 0) reps_after_fall++;
         end
      end
      check_int("hold_rise_edge", rise_edge, 6);
      check_int("hold_fall_edge", fall_edge, 36);
      check_int("hold_repeat_count", reps, REP_EN ? 7 : 0);
      check_int("hold_first_repeat", first_rep, REP_EN ? 16 : 0);
      check_int("repeat_after_fall", reps_after_fall, 0);

      // Randomised bursts with occasional resets.
      for (int n = 0; n < 300; n++) begin
         bit v;
         int len;
         v   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 20);
         if ($urandom_range(0, 39) == 0) do_reset();
         for (int j = 0; j < len; j++) cycle(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
